// File: rtl/pcie_pkg.sv
// Shared PCIe TLP definitions used by the ingress pre-parser and egress builder:
// header layout, fmt/type codes and the egress FSM state/context types.
package pcie_pkg;

    // 128-bit TLP header, DW0 in the least significant bits (fmt lives in dw0[31:29]).
    typedef struct packed {
        logic [31:0] dw3;
        logic [31:0] dw2;
        logic [31:0] dw1;
        logic [31:0] dw0;
    } tlp_head_t;

    // fmt[0]: header length
    localparam logic TLP_3DW = 1'b0;
    localparam logic TLP_4DW = 1'b1;

    // fmt/type byte (dw0[31:24]) of the TLPs this block usually carries
    localparam logic [7:0] TLP_REQ_RD = 8'h00;
    localparam logic [7:0] TLP_REQ_WD = 8'h40;
    localparam logic [7:0] TLP_CPL_WD = 8'h4A;

    localparam int SRC_CPL = 0;
    localparam int SRC_RD  = 1;
    localparam int SRC_WR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR4  = 3'd1,
        ST_DATA4 = 3'd2,
        ST_DATA3 = 3'd3,
        ST_TAIL3 = 3'd4
    } egress_st_e;

    // Complete per-packet FSM context; st is the debug-visible state.
    typedef struct packed {
        egress_st_e  st;
        logic        src_wr;
        logic        first;
        logic [95:0] carry;
        logic [11:0] carry_keep;
        tlp_head_t   hdr;
    } egress_ctx_t;

endpackage

// File: rtl/egress_rr_arb.sv
// Three-request round-robin arbiter (0=cpl, 1=rdreq, 2=wrreq) with optional
// strict completion priority; pointer advances past the winner on adv.
module egress_rr_arb
    import pcie_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       adv,
    input  logic       cpl_prio,
    output logic [2:0] grant
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_nxt;
    logic [2:0] req_m;
    logic [2:0] sum;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        req_m = req;
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        if (cpl_prio && req[SRC_CPL]) begin
            grant = 3'b001;
        end else begin
            if (cpl_prio) begin
                req_m[SRC_CPL] = 1'b0;
            end
            // Search starts at the pointer and wraps modulo 3.
            for (int i = 0; i < 3; i++) begin
                sum = {1'b0, ptr_q} + 3'(i);
                idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                if (!found && req_m[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr_q;
        if (grant[0]) begin
            ptr_nxt = 2'd1;
        end else if (grant[1]) begin
            ptr_nxt = 2'd2;
        end else if (grant[2]) begin
            ptr_nxt = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else if (adv && (|grant)) begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/egress_build_pre.sv
// Egress TLP builder: arbitrates cpl/rdreq/wrreq and merges header + payload onto
// a 128-bit PCIe AXI-stream TX port. Macro EGRESS_CPL_PRIO_EN gives cpl strict priority.
module egress_build_pre
    import pcie_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8,
    parameter int HDR_W  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] cpl_data,
    input  logic [KEEP_W-1:0] cpl_keep,
    input  logic [HDR_W-1:0]  cpl_meta,
    input  logic              cpl_eop,
    input  logic              cpl_valid,
    output logic              cpl_rdy,
    input  logic [HDR_W-1:0]  rdreq_meta,
    input  logic              rdreq_valid,
    output logic              rdreq_rdy,
    input  logic [DATA_W-1:0] wrreq_data,
    input  logic [KEEP_W-1:0] wrreq_keep,
    input  logic [HDR_W-1:0]  wrreq_meta,
    input  logic              wrreq_eop,
    input  logic              wrreq_valid,
    output logic              wrreq_rdy,
    output logic [DATA_W-1:0] m_axis_tx_tdata,
    output logic [KEEP_W-1:0] m_axis_tx_tkeep,
    output logic              m_axis_tx_sop,
    output logic              m_axis_tx_eop,
    output logic              m_axis_tx_tvalid,
    input  logic              m_axis_tx_tready
);

    generate
        if (DATA_W != 128 || KEEP_W != 16 || HDR_W != 128) begin : g_width_check
            $error("egress_build_pre supports only DATA_W=128, KEEP_W=16, HDR_W=128");
        end
    endgenerate

`ifdef EGRESS_CPL_PRIO_EN
    localparam logic CPL_PRIO = 1'b1;
`else
    localparam logic CPL_PRIO = 1'b0;
`endif

    // Handshake: an input beat transfers when *_valid && *_rdy at a rising clk edge,
    // a TX beat when tvalid && tready. rdy depends on valid only via the IDLE grant.
    egress_ctx_t       ctx_q, ctx_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              tvalid_q, tvalid_d;
    logic              cpl_rdy_c, rd_rdy_c, wr_rdy_c;

    logic              adv;
    logic [2:0]        grant;
    tlp_head_t         g_hdr;
    logic              g_is4;
    logic              g_data;
    logic [DATA_W-1:0] s_data;
    logic [KEEP_W-1:0] s_keep;
    logic              s_eop;
    logic              s_valid;

    assign adv = ~tvalid_q | m_axis_tx_tready;

    egress_rr_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      ({wrreq_valid, rdreq_valid, cpl_valid}),
        .adv      (adv && (ctx_q.st == ST_IDLE)),
        .cpl_prio (CPL_PRIO),
        .grant    (grant)
    );

    assign g_hdr  = grant[SRC_RD] ? rdreq_meta : (grant[SRC_WR] ? wrreq_meta : cpl_meta);
    assign g_is4  = (g_hdr.dw0[29] == TLP_4DW);
    assign g_data = g_hdr.dw0[30] && !grant[SRC_RD];

    assign s_data  = ctx_q.src_wr ? wrreq_data  : cpl_data;
    assign s_keep  = ctx_q.src_wr ? wrreq_keep  : cpl_keep;
    assign s_eop   = ctx_q.src_wr ? wrreq_eop   : cpl_eop;
    assign s_valid = ctx_q.src_wr ? wrreq_valid : cpl_valid;

    always_comb begin
        ctx_d     = ctx_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        tvalid_d  = tvalid_q;
        cpl_rdy_c = 1'b0;
        rd_rdy_c  = 1'b0;
        wr_rdy_c  = 1'b0;
        if (adv) begin
            tvalid_d = 1'b0;
            sop_d    = 1'b0;
            eop_d    = 1'b0;
            unique case (ctx_q.st)
                ST_IDLE: begin
                    if (|grant) begin
                        if (!g_data) begin
                            // Header-only TLP leaves in one beat.
                            tvalid_d  = 1'b1;
                            sop_d     = 1'b1;
                            eop_d     = 1'b1;
                            tdata_d   = g_is4 ? g_hdr : {32'd0, g_hdr[95:0]};
                            tkeep_d   = g_is4 ? 16'hFFFF : 16'h0FFF;
                            cpl_rdy_c = grant[SRC_CPL];
                            rd_rdy_c  = grant[SRC_RD];
                            wr_rdy_c  = grant[SRC_WR];
                        end else begin
                            ctx_d.hdr    = g_hdr;
                            ctx_d.src_wr = grant[SRC_WR];
                            ctx_d.first  = 1'b1;
                            ctx_d.st     = g_is4 ? ST_HDR4 : ST_DATA3;
                        end
                    end
                end
                ST_HDR4: begin
                    tvalid_d = 1'b1;
                    sop_d    = 1'b1;
                    tdata_d  = ctx_q.hdr;
                    tkeep_d  = 16'hFFFF;
                    ctx_d.st = ST_DATA4;
                end
                ST_DATA4: begin
                    cpl_rdy_c = ~ctx_q.src_wr;
                    wr_rdy_c  = ctx_q.src_wr;
                    if (s_valid) begin
                        tvalid_d = 1'b1;
                        tdata_d  = s_data;
                        tkeep_d  = s_keep;
                        eop_d    = s_eop;
                        if (s_eop) begin
                            ctx_d.st = ST_IDLE;
                        end
                    end
                end
                ST_DATA3: begin
                    cpl_rdy_c = ~ctx_q.src_wr;
                    wr_rdy_c  = ctx_q.src_wr;
                    if (s_valid) begin
                        // DW0 of each payload beat fills the top DW; the rest carries over.
                        tvalid_d         = 1'b1;
                        sop_d            = ctx_q.first;
                        tdata_d          = ctx_q.first ? {s_data[31:0], ctx_q.hdr[95:0]}
                                                       : {s_data[31:0], ctx_q.carry};
                        tkeep_d          = ctx_q.first ? 16'hFFFF : {s_keep[3:0], ctx_q.carry_keep};
                        ctx_d.first      = 1'b0;
                        ctx_d.carry      = s_data[127:32];
                        ctx_d.carry_keep = s_keep[15:4];
                        if (s_eop) begin
                            if (s_keep[4]) begin
                                ctx_d.st = ST_TAIL3;
                            end else begin
                                eop_d    = 1'b1;
                                ctx_d.st = ST_IDLE;
                            end
                        end
                    end
                end
                ST_TAIL3: begin
                    tvalid_d = 1'b1;
                    eop_d    = 1'b1;
                    tdata_d  = {32'd0, ctx_q.carry};
                    tkeep_d  = {4'h0, ctx_q.carry_keep};
                    ctx_d.st = ST_IDLE;
                end
                default: begin
                    ctx_d.st = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_q    <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            ctx_q    <= ctx_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            tvalid_q <= tvalid_d;
        end
    end

    // Ready is held low while reset is asserted, whatever the sources present.
    assign cpl_rdy   = rst_n & cpl_rdy_c;
    assign rdreq_rdy = rst_n & rd_rdy_c;
    assign wrreq_rdy = rst_n & wr_rdy_c;

    assign m_axis_tx_tdata  = tdata_q;
    assign m_axis_tx_tkeep  = tkeep_q;
    assign m_axis_tx_sop    = sop_q;
    assign m_axis_tx_eop    = eop_q;
    assign m_axis_tx_tvalid = tvalid_q;

endmodule

// File: doc/egress_build_pre.md
Name: egress_build_pre

Overview:
Transmit-side counterpart of the ingress pre-parser. Accepts three packet sources (completion, read request, write request), each carrying a pure 128-bit TLP header (tlp_head_t) and pure payload beats. It arbitrates between the sources, merges header and payload into a PCIe AXI-stream TX packet with sop, eop and byte keep, and realigns the payload by one DW for 3DW headers. It sits between the user request/completion engines and the PCIe core TX interface, with a 128-bit datapath.

Parameters:
DATA_W, 128, TX datapath width; only 128 is supported. Elaboration error otherwise.
KEEP_W, DATA_W/8, byte-keep width.
HDR_W, 128, header width (tlp_head_t).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpl_data  in  DATA_W  completion payload beat
cpl_keep  in  KEEP_W  byte valid of cpl_data
cpl_meta  in  HDR_W  completion header; valid on the first beat of a packet
cpl_eop  in  1  last payload beat
cpl_valid  in  1  beat valid
cpl_rdy  out  1  beat accepted when cpl_valid && cpl_rdy
rdreq_meta  in  HDR_W  read-request header; header only, no payload
rdreq_valid  in  1  request valid
rdreq_rdy  out  1  request accepted
wrreq_data, wrreq_keep, wrreq_meta, wrreq_eop, wrreq_valid  in  as cpl_*  write-request source
wrreq_rdy  out  1  write-request beat accepted
m_axis_tx_tdata  out  DATA_W  TX data
m_axis_tx_tkeep  out  KEEP_W  TX byte keep
m_axis_tx_sop  out  1  first beat of TLP
m_axis_tx_eop  out  1  last beat of TLP
m_axis_tx_tvalid  out  1  TX valid
m_axis_tx_tready  in  1  core ready

Behaviour:
- Reset: all m_axis_tx_* outputs = 0; all *_rdy = 0; FSM in IDLE; arbiter pointer = cpl; carry register = 0.
- Output stage is a single register. It loads when ~m_axis_tx_tvalid || m_axis_tx_tready (the load condition, "adv"). tvalid and tdata stay stable while stalled.
- Latency: an accepted input beat appears on m_axis_tx one cycle later.
- Header decode:
  - fmt = meta[31:29]; fmt[0]=1 means 4DW header, fmt[1]=1 means the TLP carries data.
  - rdreq is always treated as no-data, regardless of fmt[1].
- FSM states: IDLE, HDR4, DATA4, DATA3, TAIL3.
- IDLE:
  - Round-robin arbitration among valid sources in order cpl -> rdreq -> wrreq. The pointer advances to the source after the winner.
  - A grant is taken only when adv=1.
  - rdreq win, single beat, no state change except pointer:
    - 4DW: tdata = header, keep = 16'hFFFF.
    - 3DW: tdata = {32'd0, hdr[95:0]}, keep = 16'h0FFF.
    - sop = eop = 1.
  - Data source win, 4DW header: go to HDR4.
  - Data source win, 3DW header: go straight to DATA3 (see DATA3 for the beat-0 merge).
- HDR4: emit the header beat (sop=1, keep=FFFF, eop=0) without consuming payload. Then go to DATA4.
- DATA4: payload passes through unchanged (keep passed through). eop = source eop. Return to IDLE on the eop beat.
- DATA3, first beat:
  - tdata = {P0.DW0, hdr[95:0]}, sop=1, keep=FFFF.
  - carry <= P0[127:32], carry_keep <= P0.keep[15:4].
- DATA3, later beats:
  - tdata = {Pk.DW0, carry}, keep = {Pk.keep[3:0], carry_keep}.
  - carry reloads from the new beat.
- DATA3, on the payload eop beat:
  - If Pk.keep[4]=0: this beat is the TLP eop; return to IDLE.
  - If Pk.keep[4]=1: go to TAIL3, and the source is not ready that cycle.
- TAIL3: emit {32'd0, carry}, keep = {4'h0, carry_keep}, eop=1; return to IDLE.
  - Single-beat payload with keep=00FF: beat0 then a TAIL3 beat of 1 DW (keep 000F).
- *_rdy = adv && (FSM in a payload-consuming state for that source, or an IDLE grant this cycle). Never ready in HDR4 or TAIL3.
- A granted packet is never preempted; other sources wait until eop.
- Keep is assumed DW-contiguous from the LSB; other patterns are undefined.
- Reset mid-packet: drops the packet immediately; tvalid goes low asynchronously.

Optional Feature:
EGRESS_CPL_PRIO_EN
- Defined: cpl has strict priority over rdreq and wrreq at every IDLE grant; round-robin applies only between rdreq and wrreq.
- Undefined: three-way round-robin as above.

Decomposition:
- Package pcie_pkg (shared with ingress) holds:
  - tlp_head_t
  - constants TLP_3DW, TLP_4DW, TLP_REQ_WD, TLP_REQ_RD, TLP_CPL_WD
  - FSM enum egress_st_e
- Sub-module egress_rr_arb: 3-request round-robin arbiter. Inputs: req[2:0], adv, strict-cpl mode. Output: one-hot grant. Pointer register lives inside.

Test Plan:
1. rdreq, 3DW header 0x0000000A_12340001_00000001 -> one beat, sop=eop=1, keep=0FFF, tdata[127:96]=0.
2. wrreq, 4DW header plus 2 full beats -> 3 output beats: header (keep FFFF) then payload unchanged; eop on beat 3.
3. cpl, 3DW header plus 1 beat keep=00FF (DW0=0xA, DW1=0xB) -> beat0 {0xA, hdr}, then TAIL beat {0,0,0,0xB} with keep 000F and eop.
4. All three sources valid continuously with 1-beat packets -> grant order cpl, rdreq, wrreq, cpl. With EGRESS_CPL_PRIO_EN: cpl, cpl, cpl, ...
5. m_axis_tx_tready low for 5 cycles mid-packet -> tdata/tkeep stable, *_rdy=0, no beats lost or duplicated.
6. rst_n asserted during DATA3 -> tvalid=0 immediately; next packet after release starts with sop=1.
